// File: rtl/addsub_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
// Nibble width, FSM state encodings and the counter sizing helper.
package addsub_seq_ctrl_pkg;

  localparam int NIB_W = 4;

  // 2'd3 is not a legal state; the controller recovers from it to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/addsub_seq_ctrl_addsub.sv
// 4-bit two's-complement add/subtract slice; purely combinational, zero latency.
// No flow control: the sequencer presents one nibble pass per cycle.
module addsub_seq_ctrl_addsub
  import addsub_seq_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             sub_i,
  input  logic             ci_i,
  output logic [NIB_W-1:0] z_o,
  output logic             co_o,
  output logic             oflow_o
);

  logic [NIB_W-1:0] b_eff;
  logic [NIB_W:0]   sum;

  // Subtract is a + ~b + ci; the caller supplies ci=1 on the first nibble.
  assign b_eff   = b_i ^ {NIB_W{sub_i}};
  assign sum     = {1'b0, a_i} + {1'b0, b_eff} + {{NIB_W{1'b0}}, ci_i};
  assign z_o     = sum[NIB_W-1:0];
  assign co_o    = sum[NIB_W];
  assign oflow_o = (a_i[NIB_W-1] == b_eff[NIB_W-1]) && (z_o[NIB_W-1] != a_i[NIB_W-1]);

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial W-bit add/sub over one shared 4-bit slice; result valid NIBBLES edges after accept.
// Backpressure: holds result in DONE until out_ready; in_ready only in IDLE. Optional ADDSUB_SAT_EN saturates on overflow.
module addsub_seq_ctrl
  import addsub_seq_ctrl_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLES * NIB_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic         co,
  output logic         oflow
);

  localparam int            CW   = cnt_width(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_e state_q, state_d;

  logic [NIBBLES-1:0][NIB_W-1:0] a_q, a_d;
  logic [NIBBLES-1:0][NIB_W-1:0] b_q, b_d;
  logic [NIBBLES-1:0][NIB_W-1:0] z_q, z_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          sub_q, sub_d;
  logic                          carry_q, carry_d;
  logic                          co_q, co_d;
  logic                          oflow_q, oflow_d;

  logic [NIB_W-1:0] nib_a, nib_b, nib_z;
  logic             nib_co, nib_of;
  logic [W-1:0]     sat_val;

  assign nib_a = a_q[cnt_q];
  assign nib_b = b_q[cnt_q];

  addsub_seq_ctrl_addsub u_addsub (
    .a_i     (nib_a),
    .b_i     (nib_b),
    .sub_i   (sub_q),
    .ci_i    (carry_q),
    .z_o     (nib_z),
    .co_o    (nib_co),
    .oflow_o (nib_of)
  );

  // Overflow direction follows the sign of A, since overflow needs like-signed effective operands.
  assign sat_val = a_q[NIBBLES-1][NIB_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    z_d       = z_q;
    cnt_d     = cnt_q;
    sub_d     = sub_q;
    carry_d   = carry_q;
    co_d      = co_q;
    oflow_d   = oflow_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          cnt_d   = '0;
          carry_d = sub;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        z_d[cnt_q] = nib_z;
        carry_d    = nib_co;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Only the top nibble's overflow is the word overflow.
          co_d    = nib_co;
          oflow_d = nib_of;
          cnt_d   = '0;
          state_d = ST_DONE;
`ifdef ADDSUB_SAT_EN
          if (nib_of) begin
            z_d = sat_val;
          end
`endif
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      oflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      oflow_q <= oflow_d;
    end
  end

  assign z     = z_q;
  assign co    = co_q;
  assign oflow = oflow_q;

endmodule
